// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a K=3 rate-1/2 Viterbi decoder: runs the ACS phase once per
// accepted symbol, then walks survivor memory backwards and emits decoded bits.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = 4,
    parameter int TAIL_LEN  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              sym_valid_i,
    output logic              sym_ready_o,
    output logic              acs_en_o,
    output logic              pm_clr_o,
    output logic              surv_we_o,
    output logic [ADDR_W-1:0] surv_addr_o,
    output logic              tb_load_o,
    output logic              tb_en_o,
    input  logic              tb_bit_i,
    output logic              dec_bit_o,
    output logic              dec_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ACS, S_TBLD, S_TB, S_DRAIN, S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] OUT_LIMIT = ADDR_W'(FRAME_LEN - TAIL_LEN);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              accept;

    assign accept = (state_q == S_ACS) && sym_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_INIT;
            S_INIT:  state_d = S_ACS;
            S_ACS:   if (accept && (wr_cnt_q == LAST_ADDR)) state_d = S_TBLD;
            S_TBLD:  state_d = S_TB;
            S_TB:    if (rd_cnt_q == '0) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters hold at their terminal values instead of wrapping.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (state_q == S_INIT) begin
            wr_cnt_d = '0;
        end else if (accept && (wr_cnt_q != LAST_ADDR)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (state_q == S_TBLD) begin
            rd_cnt_d = LAST_ADDR;
        end else if ((state_q == S_TB) && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - 1'b1;
        end
        // Tail addresses are read but never reported as decoded bits.
        rd_pend_d = (state_q == S_TB) && (rd_cnt_q < OUT_LIMIT);
    end

    always_comb begin
        sym_ready_o = 1'b0;
        acs_en_o    = 1'b0;
        pm_clr_o    = 1'b0;
        surv_we_o   = 1'b0;
        surv_addr_o = '0;
        tb_load_o   = 1'b0;
        tb_en_o     = 1'b0;
        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        unique case (state_q)
            S_INIT: pm_clr_o = 1'b1;
            S_ACS: begin
                sym_ready_o = 1'b1;
                acs_en_o    = sym_valid_i;
                surv_we_o   = sym_valid_i;
                surv_addr_o = wr_cnt_q;
            end
            S_TBLD: tb_load_o = 1'b1;
            S_TB: begin
                tb_en_o     = 1'b1;
                surv_addr_o = rd_cnt_q;
            end
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign dec_valid_o = rd_pend_q;
    assign dec_bit_o   = rd_pend_q & tb_bit_i;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: frame timeline model plus a survivor-memory stand-in
// that stores the true message bit per trellis step.
module tb_viterbi_frame_ctrl;

    localparam int FL = 16;
    localparam int AW = 4;
    localparam int TL = 2;
    localparam int NB = FL - TL;

    logic          clk_i = 1'b0;
    logic          rst_i, start_i, sym_valid_i, tb_bit_i;
    logic          sym_ready_o, acs_en_o, pm_clr_o, surv_we_o;
    logic [AW-1:0] surv_addr_o;
    logic          tb_load_o, tb_en_o, dec_bit_o, dec_valid_o, busy_o, done_o;

    int            checks = 0;
    int            errors = 0;
    logic          cur_bit;
    logic          mem [0:FL-1];
    logic          dec_q [$];

    always #5 clk_i = ~clk_i;

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .ADDR_W(AW), .TAIL_LEN(TL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sym_valid_i(sym_valid_i),
        .sym_ready_o(sym_ready_o), .acs_en_o(acs_en_o), .pm_clr_o(pm_clr_o),
        .surv_we_o(surv_we_o), .surv_addr_o(surv_addr_o), .tb_load_o(tb_load_o),
        .tb_en_o(tb_en_o), .tb_bit_i(tb_bit_i), .dec_bit_o(dec_bit_o),
        .dec_valid_o(dec_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    // Survivor memory / traceback stand-in: one-cycle read latency.
    always @(posedge clk_i) begin
        if (surv_we_o) mem[surv_addr_o] <= cur_bit;
        tb_bit_i <= tb_en_o ? mem[surv_addr_o] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Order: ready, acs_en, pm_clr, surv_we, tb_load, tb_en, busy, done
    task automatic expect_ctrl(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, sym_ready_o, acs_en_o, pm_clr_o, surv_we_o,
                  tb_load_o, tb_en_o, busy_o, done_o}, {24'd0, exp});
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            expect_ctrl(tag, 8'b0000_0000);
            chk({tag, "_addr"}, 32'(surv_addr_o), 32'd0);
            chk({tag, "_dec"}, {30'd0, dec_valid_o, dec_bit_o}, 32'd0);
        end
    endtask

    // mode 0: valid always; 1: valid on every third cycle; 2: random valid
    task automatic run_frame(input int mode, input logic [NB-1:0] m,
                             input bit hold_start, input int rst_at);
        int acc;
        int guard;
        logic v;
        dec_q.delete();
        @(posedge clk_i); #1;
        start_i = 1'b1; sym_valid_i = 1'b0;
        @(negedge clk_i);
        expect_ctrl("idle_start", 8'b0000_0000);
        @(posedge clk_i); #1;
        start_i = hold_start; sym_valid_i = 1'b1;
        @(negedge clk_i);
        expect_ctrl("init", 8'b0010_0010);
        acc = 0; guard = 0;
        while (acc < FL && guard < 200) begin
            @(posedge clk_i); #1;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(guard % 3 == 0)
                                                   : logic'($urandom_range(0, 1));
            sym_valid_i = v;
            cur_bit = (acc < NB) ? m[acc] : 1'b0;
            rst_i = (rst_at >= 0) && (acc == rst_at) && v;
            @(negedge clk_i);
            expect_ctrl("acs", {1'b1, v, 1'b0, v, 4'b0010});
            if (v) chk("wr_addr", 32'(surv_addr_o), 32'(acc));
            if (rst_i) begin
                @(posedge clk_i); #1;
                rst_i = 1'b0;
                @(negedge clk_i);
                expect_ctrl("after_rst", 8'b0000_0000);
                chk("after_rst_addr", 32'(surv_addr_o), 32'd0);
                sym_valid_i = 1'b0;
                start_i = 1'b0;
                idle_cycles("rst_idle", 4);
                return;
            end
            if (v) acc++;
            guard++;
        end
        chk("accept_budget", 32'(acc), 32'(FL));
        @(posedge clk_i); #1;
        sym_valid_i = 1'b1;
        @(negedge clk_i);
        expect_ctrl("tbld", 8'b0000_1010);
        for (int k = 0; k < FL; k++) begin
            @(posedge clk_i); #1;
            start_i = hold_start | (k == 5);
            sym_valid_i = logic'($urandom_range(0, 1));
            @(negedge clk_i);
            expect_ctrl("tb", 8'b0000_0110);
            chk("rd_addr", 32'(surv_addr_o), 32'(FL - 1 - k));
            chk("tb_dec_valid", 32'(dec_valid_o), 32'(k >= 3));
            if (dec_valid_o) dec_q.push_back(dec_bit_o);
        end
        @(posedge clk_i); #1;
        start_i = hold_start;
        @(negedge clk_i);
        expect_ctrl("drain", 8'b0000_0010);
        chk("drain_dec_valid", 32'(dec_valid_o), 32'd1);
        if (dec_valid_o) dec_q.push_back(dec_bit_o);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        expect_ctrl("done", 8'b0000_0011);
        chk("done_dec_valid", 32'(dec_valid_o), 32'd0);
        sym_valid_i = 1'b0;
        chk("dec_count", 32'(dec_q.size()), 32'(NB));
        for (int i = 0; i < NB && i < dec_q.size(); i++)
            chk("dec_bit", 32'(dec_q[i]), 32'(m[NB - 1 - i]));
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; sym_valid_i = 1'b0; cur_bit = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle_cycles("reset_idle", 10);
        run_frame(0, 14'b01011001110010, 1'b0, -1);
        idle_cycles("gap", 2);
        run_frame(1, 14'($urandom), 1'b0, -1);
        run_frame(0, 14'($urandom), 1'b0, 6);
        run_frame(0, 14'($urandom), 1'b0, -1);
        idle_cycles("gap2", 1);
        run_frame(2, 14'($urandom), 1'b1, -1);
        run_frame(2, 14'($urandom), 1'b1, -1);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        expect_ctrl("final_idle", 8'b0000_0000);
        idle_cycles("tail_idle", 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
